// File: rtl/note_chart_scheduler.sv
// note_chart_scheduler
//   Walks a note chart held in an external synchronous ROM and emits each
//   note code as a one-cycle pulse on seq_out for the note-slot allocator.
//   Each chart entry is {wait[WAIT_W-1:0], code[2:0]}. The wait is counted in
//   beat ticks of TICK_DIV clock cycles. Code 3'b111 marks the end of the
//   chart. Code 3'b000 is a rest: it consumes its wait and emits nothing.
//   Optional feature macro: CHART_LOOP_EN. When it is defined, the chart
//   restarts from address 0 on end-of-chart or address wrap, done pulses
//   once per pass, and the loop_cnt output counts passes.

module note_chart_scheduler #(
    parameter int ADDR_W   = 8,
    parameter int TICK_DIV = 4,
    parameter int WAIT_W   = 5
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              start,
    input  logic              pause,
    input  logic              slot_free,
    input  logic [WAIT_W+2:0] rom_data,
    output logic [ADDR_W-1:0] rom_addr,
    output logic [2:0]        seq_out,
    output logic              busy,
    output logic              done,
    output logic [7:0]        note_cnt,
    output logic              stall
`ifdef CHART_LOOP_EN
   ,output logic [7:0]        loop_cnt
`endif
);

    // Tick divider phase width; at least one bit even when TICK_DIV is 1.
    localparam int DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(TICK_DIV - 1);
    localparam logic [ADDR_W-1:0] ADDR_LAST = {ADDR_W{1'b1}};
    localparam logic [2:0]        END_CODE  = 3'b111;
    localparam logic [2:0]        REST_CODE = 3'b000;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        LOAD  = 3'd2,
        WAIT  = 3'd3,
        ISSUE = 3'd4,
        DONE  = 3'd5
    } state_t;

    state_t            state;
    logic [2:0]        code;      // note code of the entry being played
    logic [WAIT_W-1:0] wcnt;      // beat ticks still to elapse
    logic [DIV_W-1:0]  div_cnt;   // clock cycles elapsed inside current tick

    logic [WAIT_W-1:0] entry_wait;
    logic [2:0]        entry_code;

    assign entry_wait = rom_data[WAIT_W+2:3];
    assign entry_code = rom_data[2:0];

    // A note is blocked exactly while the FSM sits in ISSUE without a free slot.
    // NOTE: stall is decoded from the state register and the live slot_free so
    // it is high in the same cycle the allocator reports no free slot; a
    // registered version would lag by one cycle.
    assign stall = (state == ISSUE) && !slot_free;

    // Chart-walking FSM together with every registered output.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state    <= IDLE;
            rom_addr <= '0;
            seq_out  <= 3'b000;
            busy     <= 1'b0;
            done     <= 1'b0;
            note_cnt <= 8'd0;
            code     <= 3'b000;
            wcnt     <= '0;
            div_cnt  <= '0;
`ifdef CHART_LOOP_EN
            loop_cnt <= 8'd0;
`endif
        end else begin
            // NOTE: state is updated with non-blocking assignments only, so
            // every branch below reads the values from before this edge. The
            // pulse default sits outside the pause gate: a note pulse always
            // clears after one cycle even if pause rises while it is high.
            seq_out <= 3'b000;

            if (!pause) begin
`ifdef CHART_LOOP_EN
                done <= 1'b0;
`endif
                unique case (state)
                    IDLE: begin
                        if (start) begin
                            state    <= FETCH;
                            busy     <= 1'b1;
                            rom_addr <= '0;
                            note_cnt <= 8'd0;
                        end
                    end

                    // rom_addr is stable; the ROM registers the entry this edge.
                    FETCH: begin
                        state <= LOAD;
                    end

                    LOAD: begin
                        code <= entry_code;
                        if (entry_code == END_CODE) begin
`ifdef CHART_LOOP_EN
                            rom_addr <= '0;
                            state    <= FETCH;
                            done     <= 1'b1;
                            if (loop_cnt != 8'hFF) begin
                                loop_cnt <= loop_cnt + 8'd1;
                            end
`else
                            state <= DONE;
                            busy  <= 1'b0;
`endif
                        end else begin
                            // Remaining wait is wcnt*TICK_DIV - div_cnt cycles.
                            wcnt    <= entry_wait;
                            div_cnt <= '0;
                            state   <= (entry_wait == '0) ? ISSUE : WAIT;
                        end
                    end

                    // Leave on the last cycle of the last tick.
                    WAIT: begin
                        if (div_cnt == DIV_LAST) begin
                            div_cnt <= '0;
                            if (wcnt == WAIT_W'(1)) begin
                                wcnt  <= '0;
                                state <= ISSUE;
                            end else begin
                                wcnt <= wcnt - WAIT_W'(1);
                            end
                        end else begin
                            div_cnt <= div_cnt + DIV_W'(1);
                        end
                    end

                    // Hold the note until the allocator has room; never drop it.
                    ISSUE: begin
                        if (slot_free) begin
                            seq_out <= code;
                            if (code != REST_CODE && note_cnt != 8'hFF) begin
                                note_cnt <= note_cnt + 8'd1;
                            end
                            if (rom_addr == ADDR_LAST) begin
`ifdef CHART_LOOP_EN
                                rom_addr <= '0;
                                state    <= FETCH;
                                done     <= 1'b1;
                                if (loop_cnt != 8'hFF) begin
                                    loop_cnt <= loop_cnt + 8'd1;
                                end
`else
                                state <= DONE;
                                busy  <= 1'b0;
`endif
                            end else begin
                                rom_addr <= rom_addr + ADDR_W'(1);
                                state    <= FETCH;
                            end
                        end
                    end

                    // done rises on the first DONE cycle and is held at least
                    // one cycle; a low start then returns to IDLE.
                    DONE: begin
                        if (!done) begin
                            done <= 1'b1;
                        end else if (!start) begin
                            done  <= 1'b0;
                            state <= IDLE;
                        end
                    end

                    default: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_note_chart_scheduler.sv
// Testbench for note_chart_scheduler (default build, chart looping disabled).
// Table-driven single-note charts, hand-written stall/pause/reset/wrap
// sequences, and randomized play against a cycle-budget reference model.

module tb_note_chart_scheduler;

    localparam int ADDR_W   = 8;
    localparam int TICK_DIV = 4;
    localparam int WAIT_W   = 5;
    localparam int LOG_N    = 1024;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       start = 1'b0;
    logic       pause = 1'b0;
    logic       slot_free = 1'b1;
    logic [7:0] rom_data;
    logic [7:0] rom_addr;
    logic [2:0] seq_out;
    logic       busy;
    logic       done;
    logic [7:0] note_cnt;
    logic       stall;
`ifdef CHART_LOOP_EN
    logic [7:0] loop_cnt;
`endif

    logic [7:0] rom [0:255];

    int n_cmp = 0;
    int n_err = 0;

    // Per-cycle output logs filled by run_play.
    logic [2:0] seq_log   [0:LOG_N-1];
    logic       stall_log [0:LOG_N-1];
    logic       done_log  [0:LOG_N-1];
    logic       busy_log  [0:LOG_N-1];
    logic [7:0] addr_log  [0:LOG_N-1];
    logic [7:0] cnt_log   [0:LOG_N-1];

    note_chart_scheduler #(
        .ADDR_W   (ADDR_W),
        .TICK_DIV (TICK_DIV),
        .WAIT_W   (WAIT_W)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .start     (start),
        .pause     (pause),
        .slot_free (slot_free),
        .rom_data  (rom_data),
        .rom_addr  (rom_addr),
        .seq_out   (seq_out),
        .busy      (busy),
        .done      (done),
        .note_cnt  (note_cnt),
        .stall     (stall)
`ifdef CHART_LOOP_EN
       ,.loop_cnt  (loop_cnt)
`endif
    );

    always #5 CLK = ~CLK;

    // Synchronous chart ROM: data valid one cycle after the address.
    always_ff @(posedge CLK) begin
        rom_data <= rom[rom_addr];
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic fill_rom(input logic [7:0] v);
        for (int i = 0; i < 256; i++) rom[i] = v;
    endtask

    task automatic do_reset();
        @(negedge CLK);
        RST = 1'b1;
        start = 1'b0;
        pause = 1'b0;
        slot_free = 1'b1;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        RST = 1'b0;
    endtask

    // start is high for exactly one edge: that edge is cycle 0.
    task automatic start_play();
        @(negedge CLK);
        start = 1'b1;
        @(posedge CLK);
    endtask

    // Plays ncyc cycles; pause / slot_free=0 are applied to the edge that
    // follows cycle indices inside [lo,hi]. Outputs are logged per cycle.
    task automatic run_play(input int ncyc, input int p_lo, input int p_hi,
                            input int s_lo, input int s_hi);
        for (int cyc = 0; cyc < ncyc; cyc++) begin
            @(negedge CLK);
            start     = 1'b0;
            pause     = (cyc >= p_lo && cyc <= p_hi);
            slot_free = !(cyc >= s_lo && cyc <= s_hi);
            #1;
            seq_log[cyc]   = seq_out;
            stall_log[cyc] = stall;
            done_log[cyc]  = done;
            busy_log[cyc]  = busy;
            addr_log[cyc]  = rom_addr;
            cnt_log[cyc]   = note_cnt;
        end
        @(negedge CLK);
        pause = 1'b0;
        slot_free = 1'b1;
    endtask

    // ---------------- reference model ----------------
    // Each entry costs 2 unpaused cycles to fetch plus wait*TICK_DIV unpaused
    // cycles of waiting; the note leaves on the next unpaused cycle with a
    // free slot. An end entry finishes the chart after its fetch cycles.
    typedef enum logic [1:0] {M_IDLE, M_RUN, M_DONE1, M_DONE2} mphase_t;

    mphase_t    m_phase;
    int         m_idx;
    int         m_need;
    logic       m_term;
    logic [2:0] m_code;
    int         m_cnt;
    logic [2:0] m_seq;
    logic       m_busy;
    logic       m_done;

    task automatic model_reset();
        m_phase = M_IDLE;
        m_idx = 0; m_need = 0; m_term = 1'b0; m_code = 3'b000;
        m_cnt = 0; m_seq = 3'b000; m_busy = 1'b0; m_done = 1'b0;
    endtask

    task automatic model_load();
        logic [7:0] e;
        e = rom[m_idx];
        m_code = e[2:0];
        m_term = (e[2:0] == 3'b111);
        m_need = 2 + (m_term ? 0 : int'(e[7:3]) * TICK_DIV);
    endtask

    task automatic model_step(input logic st, input logic ps, input logic sf);
        m_seq = 3'b000;
        if (!ps) begin
            case (m_phase)
                M_IDLE: if (st) begin
                    m_phase = M_RUN; m_idx = 0; m_cnt = 0; m_busy = 1'b1;
                    model_load();
                end
                M_RUN: begin
                    if (m_need > 0) begin
                        m_need--;
                        if (m_need == 0 && m_term) begin
                            m_phase = M_DONE1; m_busy = 1'b0;
                        end
                    end else if (sf) begin
                        m_seq = m_code;
                        if (m_code != 3'b000 && m_cnt < 255) m_cnt++;
                        if (m_idx == 255) begin
                            m_phase = M_DONE1; m_busy = 1'b0;
                        end else begin
                            m_idx++;
                            model_load();
                        end
                    end
                end
                M_DONE1: begin
                    m_done = 1'b1; m_phase = M_DONE2;
                end
                default: if (!st) begin
                    m_done = 1'b0; m_phase = M_IDLE;
                end
            endcase
        end
    endtask

    // ---------------- stimulus table ----------------
    typedef struct {
        int w;         // wait field of entry 0
        int c;         // code of entry 0 (entry 1 is end-of-chart)
        int seq_cyc;   // cycle of the note pulse, -1 for none
        int done_cyc;  // first cycle with done=1
        int cnt;       // final note_cnt
    } vec_t;

    vec_t vecs [7];

    initial begin
        int first_seq, first_done, pulses, exp_pulses, len;
        logic [2:0] seq_val;
        logic [31:0] exp_v;

        vecs[0] = '{2, 1, 11, 14, 1};
        vecs[1] = '{0, 2, 3, 6, 1};
        vecs[2] = '{1, 5, 7, 10, 1};
        vecs[3] = '{3, 0, -1, 18, 0};
        vecs[4] = '{5, 6, 23, 26, 1};
        vecs[5] = '{31, 3, 127, 130, 1};
        vecs[6] = '{4, 7, -1, 3, 0};

        // Reset state
        fill_rom(8'h07);
        do_reset();
        #1;
        check("reset_rom_addr", rom_addr, 0);
        check("reset_seq_out", seq_out, 0);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_note_cnt", note_cnt, 0);
        check("reset_stall", stall, 0);

        // Table: one-note charts
        for (int r = 0; r < 7; r++) begin
            fill_rom(8'h07);
            rom[0] = {5'(vecs[r].w), 3'(vecs[r].c)};
            do_reset();
            start_play();
            run_play(150, -1, -1, -1, -1);
            first_seq = -1; first_done = -1; pulses = 0; seq_val = 3'b000;
            for (int k = 0; k < 150; k++) begin
                if (seq_log[k] != 3'b000) begin
                    pulses++;
                    if (first_seq < 0) begin
                        first_seq = k;
                        seq_val = seq_log[k];
                    end
                end
                if (done_log[k] && first_done < 0) first_done = k;
            end
            exp_pulses = (vecs[r].seq_cyc >= 0) ? 1 : 0;
            check($sformatf("vec%0d_seq_cycle", r), first_seq, vecs[r].seq_cyc);
            check($sformatf("vec%0d_seq_value", r), seq_val,
                  (vecs[r].seq_cyc >= 0) ? vecs[r].c : 0);
            check($sformatf("vec%0d_pulses", r), pulses, exp_pulses);
            check($sformatf("vec%0d_done_cycle", r), first_done, vecs[r].done_cyc);
            check($sformatf("vec%0d_note_cnt", r), cnt_log[149], vecs[r].cnt);
            check($sformatf("vec%0d_busy_c0", r), busy_log[0], 1);
        end

        // Stall: slot_free low for the edges after cycles 0..11
        fill_rom(8'h07);
        rom[0] = {5'd0, 3'd3};
        do_reset();
        start_play();
        run_play(20, -1, -1, 0, 11);
        pulses = 0; first_seq = 0;
        for (int k = 0; k < 20; k++) begin
            if (stall_log[k]) pulses++;
            if (k <= 12 && seq_log[k] != 3'b000) first_seq++;
        end
        check("stall_cycles", pulses, 10);
        check("stall_c2", stall_log[2], 1);
        check("stall_c11", stall_log[11], 1);
        check("stall_no_early_seq", first_seq, 0);
        check("stall_seq_c13", seq_log[13], 3);
        check("stall_seq_c14", seq_log[14], 0);
        check("stall_addr_c13", addr_log[13], 1);
        check("stall_note_cnt", cnt_log[19], 1);

        // Pause for 5 edges during WAIT delays the note by 5 cycles
        fill_rom(8'h07);
        rom[0] = {5'd2, 3'd1};
        do_reset();
        start_play();
        run_play(25, 4, 8, -1, -1);
        check("pause_wait_c11", seq_log[11], 0);
        check("pause_wait_c15", seq_log[15], 0);
        check("pause_wait_c16", seq_log[16], 1);
        check("pause_wait_c17", seq_log[17], 0);

        // Pause rising while seq_out is high still clears the pulse
        fill_rom(8'h07);
        rom[0] = {5'd0, 3'd2};
        rom[1] = {5'd0, 3'd5};
        do_reset();
        start_play();
        run_play(16, 3, 5, -1, -1);
        check("pause_pulse_c3", seq_log[3], 2);
        check("pause_pulse_c4", seq_log[4], 0);
        check("pause_pulse_c9", seq_log[9], 5);
        check("pause_pulse_cnt", cnt_log[15], 2);

        // Pause and slot_free together in ISSUE: pause wins
        fill_rom(8'h07);
        rom[0] = {5'd0, 3'd4};
        do_reset();
        start_play();
        run_play(10, 2, 4, -1, -1);
        check("pause_issue_c3", seq_log[3], 0);
        check("pause_issue_c6", seq_log[6], 4);

        // Reset during WAIT of the second entry
        fill_rom(8'h07);
        rom[0] = {5'd0, 3'd2};
        rom[1] = {5'd5, 3'd1};
        do_reset();
        start_play();
        run_play(9, -1, -1, -1, -1);
        check("rst_pre_addr", addr_log[8], 1);
        check("rst_pre_cnt", cnt_log[8], 1);
        @(negedge CLK);
        RST = 1'b1;
        #1;
        check("rst_mid_addr", rom_addr, 0);
        check("rst_mid_seq", seq_out, 0);
        check("rst_mid_busy", busy, 0);
        check("rst_mid_done", done, 0);
        check("rst_mid_cnt", note_cnt, 0);
        @(negedge CLK);
        RST = 1'b0;

        // Full 256-entry chart: no end code, address wrap ends play
        fill_rom({5'd0, 3'd1});
        do_reset();
        start_play();
        run_play(800, -1, -1, -1, -1);
        pulses = 0;
        for (int k = 0; k < 800; k++) if (seq_log[k] == 3'd1) pulses++;
        check("wrap_pulses", pulses, 256);
        check("wrap_last_seq", seq_log[768], 1);
        check("wrap_done_c768", done_log[768], 0);
        check("wrap_done_c769", done_log[769], 1);
        check("wrap_note_cnt_sat", cnt_log[799], 255);
        check("wrap_addr_held", addr_log[799], 255);

        // Randomized play against the reference model
        for (int t = 0; t < 6; t++) begin
            len = $urandom_range(1, 10);
            fill_rom(8'h07);
            for (int i = 0; i < len; i++) begin
                rom[i] = {5'($urandom_range(0, 4)), 3'($urandom_range(0, 6))};
            end
            do_reset();
            model_reset();
            for (int cyc = 0; cyc < 300; cyc++) begin
                @(negedge CLK);
                start     = ($urandom_range(0, 99) < 20);
                pause     = ($urandom_range(0, 99) < 15);
                slot_free = ($urandom_range(0, 99) < 70);
                #1;
                exp_v = {10'd0, m_seq, m_busy, m_done,
                         (m_phase == M_RUN && m_need == 0 && !slot_free),
                         8'(m_cnt), 8'(m_idx)};
                check($sformatf("rand%0d_cyc%0d {seq,busy,done,stall,cnt,addr}", t, cyc),
                      {10'd0, seq_out, busy, done, stall, note_cnt, rom_addr}, exp_v);
                @(posedge CLK);
                model_step(start, pause, slot_free);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
